// File: rtl/conv_viterbi_codec.sv
// conv_viterbi_codec: rate-1/2 K=3 (7,5) convolutional encoder plus 4-state hard-decision Viterbi decoder
module conv_viterbi_codec #(
    parameter int TB_DEPTH = 32,
    parameter int PM_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_enable_i,
    input  logic       enc_d_in,
    output logic       enc_valid_o,
    output logic [1:0] enc_d_out,
    input  logic       dec_enable,
    input  logic [1:0] dec_d_in,
    output logic       dec_d_out
);
    localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

    logic [1:0]          enc_sr_q;
    logic [PM_W-1:0]     pm_q [4];
    logic [PM_W-1:0]     pm_d [4];
    logic [PM_W-1:0]     raw [4];
    logic [TB_DEPTH-2:0] surv_q [4];
    logic [TB_DEPTH-1:0] surv_d [4];
    logic [PM_W-1:0]     min01, min23, pm_min;
    logic [1:0]          best01, best23, best;

    function automatic logic [1:0] hd(input logic [1:0] a, input logic [1:0] b);
        return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
        logic [PM_W:0] s;
        s = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
        return (s > PM_MAX) ? {PM_W{1'b1}} : s[PM_W-1:0];
    endfunction

    // Encoder: shift in the new bit and emit {g0,g1}; valid tracks the enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_sr_q    <= '0;
            enc_d_out   <= '0;
            enc_valid_o <= 1'b0;
        end else begin
            enc_valid_o <= enc_enable_i;
            if (enc_enable_i) begin
                enc_d_out <= {enc_d_in ^ enc_sr_q[1] ^ enc_sr_q[0], enc_d_in ^ enc_sr_q[0]};
                enc_sr_q  <= {enc_d_in, enc_sr_q[1]};
            end
        end
    end

    // Add-compare-select per next state n={b,p1}; predecessors {p1,0} and {p1,1}, tie keeps s0=0
    for (genvar g = 0; g < 4; g++) begin : acs
        localparam logic [1:0] N = 2'(g);
        logic [PM_W-1:0] c0, c1;
        logic            sel;
        assign c0        = sat_add(pm_q[{N[0], 1'b0}], hd(dec_d_in, {N[1] ^ N[0], N[1]}));
        assign c1        = sat_add(pm_q[{N[0], 1'b1}], hd(dec_d_in, {~(N[1] ^ N[0]), ~N[1]}));
        assign sel       = c1 < c0;
        assign raw[g]    = sel ? c1 : c0;
        assign surv_d[g] = {surv_q[{N[0], sel}], N[1]};
        assign pm_d[g]   = raw[g] - pm_min;
    end

    // Minimum metric and best state, lowest index wins ties
    always_comb begin
        best01 = (raw[1] < raw[0]) ? 2'd1 : 2'd0;
        min01  = (raw[1] < raw[0]) ? raw[1] : raw[0];
        best23 = (raw[3] < raw[2]) ? 2'd3 : 2'd2;
        min23  = (raw[3] < raw[2]) ? raw[3] : raw[2];
        best   = (min23 < min01) ? best23 : best01;
        pm_min = (min23 < min01) ? min23 : min01;
    end

    // Decoder state: normalized metrics, register-exchange survivors, oldest bit of best path out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_W'(8);
                surv_q[i] <= '0;
            end
            dec_d_out <= 1'b0;
        end else if (dec_enable) begin
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= pm_d[i];
                surv_q[i] <= surv_d[i][TB_DEPTH-2:0];
            end
            dec_d_out <= surv_d[best][TB_DEPTH-1];
        end
    end
endmodule

// File: tb/tb_conv_viterbi_codec.sv
// tb_conv_viterbi_codec: directed checks of encoder, loopback decoding, bursts, gaps and mid-run reset
module tb_conv_viterbi_codec;
    localparam int D = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enc_enable_i = 1'b0;
    logic       enc_d_in = 1'b0;
    logic       enc_valid_o;
    logic [1:0] enc_d_out;
    logic       dec_enable = 1'b0;
    logic [1:0] dec_d_in = 2'b00;
    logic       dec_d_out;

    int         checks = 0;
    int         errors = 0;
    int         nacc = 0;
    int         cyc = 0;
    logic       bits[$];
    logic [1:0] sr = 2'b00;
    logic [1:0] m_sym = 2'b00;
    logic       m_dec = 1'b0;
    logic [1:0] chan_d = 2'b00;
    logic       chan_v = 1'b0;
    logic [5:0] pat = 6'b001101;
    logic [1:0] es [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

    always #5 clk = ~clk;

    conv_viterbi_codec #(.TB_DEPTH(D), .PM_W(6)) dut (
        .clk(clk), .rst(rst),
        .enc_enable_i(enc_enable_i), .enc_d_in(enc_d_in),
        .enc_valid_o(enc_valid_o), .enc_d_out(enc_d_out),
        .dec_enable(dec_enable), .dec_d_in(dec_d_in), .dec_d_out(dec_d_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_enc_valid"}, enc_valid_o, 0);
        chk({tag, "_enc_sym"}, enc_d_out, 0);
        chk({tag, "_dec_out"}, dec_d_out, 0);
        for (int i = 0; i < 4; i++) chk({tag, "_pm"}, dut.pm_q[i], (i == 0) ? 0 : 8);
    endtask

    task automatic model_clear();
        bits.delete();
        nacc = 0; sr = 2'b00; m_sym = 2'b00; m_dec = 1'b0;
        chan_d = 2'b00; chan_v = 1'b0;
        dec_d_in = 2'b00; dec_enable = 1'b0;
    endtask

    task automatic step(input logic en, input logic b, input logic flip);
        logic acc;
        logic [1:0] nsym;
        enc_enable_i = en;
        enc_d_in = b;
        acc = dec_enable;
        nsym = {b ^ sr[1] ^ sr[0], b ^ sr[0]};
        @(posedge clk);
        #1;
        if (en) begin
            bits.push_back(b);
            sr = {b, sr[1]};
            m_sym = nsym;
        end
        chk("enc_valid", enc_valid_o, en);
        chk("enc_sym", enc_d_out, m_sym);
        if (acc) nacc++;
        if (nacc >= D) begin
            if (acc) begin
                m_dec = bits[nacc-D];
                chk("dec_bit", dec_d_out, m_dec);
            end else begin
                chk("dec_hold", dec_d_out, m_dec);
            end
        end
        dec_d_in = chan_d ^ {1'b0, flip};
        dec_enable = chan_v;
        chan_d = enc_d_out;
        chan_v = enc_valid_o;
        cyc++;
    endtask

    initial begin
        repeat (4) begin
            @(posedge clk);
            #1;
            enc_enable_i = 1'($urandom);
            enc_d_in = 1'($urandom);
            dec_enable = 1'($urandom);
            dec_d_in = 2'($urandom);
        end
        chk_reset_state("rst");
        enc_enable_i = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("pre_valid", enc_valid_o, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, pat[i], (cyc % 16) >= 14);
            chk("enc_dir", enc_d_out, es[i]);
        end
        while (cyc < 500) step(1'b1, 1'($urandom), (cyc < 256) && ((cyc % 16) >= 14));
        rst = 1'b0;
        #1;
        chk_reset_state("midrst");
        enc_enable_i = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_reset_state("midrst_hold");
        repeat (400) step(1'b1, 1'($urandom), 1'b0);
        repeat (600) step(1'($urandom), 1'($urandom), 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
